imem_loader: RTL and testbench

//  Byte-stream program loader; the write side of the 256-word instruction memory.
//  - Accepts a framed byte stream over a valid/ready handshake.
//  - Packs bytes little-endian into 32-bit words and writes them to consecutive word addresses from 0.
//  - Holds the single-cycle processor via cpu_hold while a load is in progress.
//  - Sits between the host/serial front end and the instruction memory write port.

---
 rtl/imem_pkg.sv | 28 ++
 rtl/byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 189 ++++++++++++++++++
 tb/tb_imem_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_pkg
//  Purpose  : Shared constants and loader state type for the instruction-memory
//             byte-stream loader.
//  Revision : 1.0  initial release
// ============================================================================
package imem_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;
    localparam int WORD_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int LEN_W       = 16;
    localparam int BYTE_IDX_W  = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_packer
//  Purpose  : Little-endian byte-to-word packer; flags the 4th byte of a word.
//  Revision : 1.0  initial release
// ============================================================================
module byte_packer
    import imem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic [BYTE_IDX_W-1:0] byte_idx,
    input  logic [BYTE_W-1:0]     in_byte,
    output logic [WORD_W-1:0]     word,
    output logic                  word_ready
);

    logic [WORD_W-1:0] r_word;

    // Newest byte enters at the top, so after four shifts byte0 sits in [7:0].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= '0;
        end else if (shift_en) begin
            r_word <= {in_byte, r_word[WORD_W-1:BYTE_W]};
        end
    end

    assign word       = {in_byte, r_word[WORD_W-1:BYTE_W]};
    assign word_ready = shift_en && (byte_idx == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Framed byte-stream loader driving the instruction-memory write
//             port; holds the CPU while loading. Optional trailing checksum
//             byte enabled by IMEM_LOADER_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic [BYTE_W-1:0]     r_len_lo;
    logic [ADDR_W:0]       r_len;
    logic [ADDR_W:0]       r_words;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [WORD_W-1:0]     r_mem_wdata;
    logic                  r_error;

    logic              w_xfer;
    logic              w_shift;
    logic              w_word_ready;
    logic [WORD_W-1:0] w_packed;
    logic [LEN_W-1:0]  w_len;
    logic              w_last_word;
    logic              w_start_ok;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_csum;
`endif

    assign w_xfer      = in_valid && in_ready;
    assign w_shift     = (r_state == DATA) && w_xfer;
    assign w_len       = {in_data, r_len_lo};
    assign w_last_word = ((r_words + 1'b1) == r_len);
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == ERR));

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (w_shift),
        .byte_idx   (r_byte_idx),
        .in_byte    (in_data),
        .word       (w_packed),
        .word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        cpu_hold     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = LEN0;
            end
            LEN0: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_state_next = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (w_xfer) begin
                    if (w_len == '0)
                        w_state_next = DONE;
                    else if (w_len > LEN_W'(DEPTH))
                        w_state_next = ERR;
                    else
                        w_state_next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (w_word_ready && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_next = CSUM;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_state_next = (in_data == r_csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            ERR: begin
                if (start) w_state_next = LEN0;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The write for a word lands one cycle after its 4th byte is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_lo    <= '0;
            r_len       <= '0;
            r_words     <= '0;
            r_byte_idx  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_error     <= 1'b0;
        end else begin
            r_mem_we <= w_word_ready;
            if (w_start_ok) begin
                r_error    <= 1'b0;
                r_words    <= '0;
                r_byte_idx <= '0;
            end
            if ((r_state == LEN0) && w_xfer) r_len_lo <= in_data;
            if ((r_state == LEN1) && w_xfer) r_len <= w_len[ADDR_W:0];
            if (w_shift) r_byte_idx <= r_byte_idx + 2'd1;
            if (w_word_ready) begin
                r_mem_addr  <= r_words[ADDR_W-1:0];
                r_mem_wdata <= w_packed;
                r_words     <= r_words + 1'b1;
            end
            if ((w_state_next == ERR) && (r_state != ERR)) r_error <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if (w_shift) begin
            r_csum <= r_csum + in_data;
        end
    end
`endif

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Directed self-checking bench for imem_loader with a frame-level
//             model of the expected memory writes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    bit mon_en = 1'b0;

    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Every write must match the next entry the model predicted, in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_seen++;
            if (mem_we) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%h data=%h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    chk("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                    chk("wr_data", mem_wdata, exp_data_q.pop_front());
                end
            end
            if (error) chk("hold_in_err", 32'(cpu_hold), 32'd0);
        end
    end

    // Frame model: length header, little-endian words, optional mod-256 sum.
    task automatic build(input logic [31:0] w[$], input int n, output logic [7:0] b[$]);
        logic [7:0] s;
        logic [7:0] x;
        s = 8'h00;
        b = {};
        b.push_back(n[7:0]);
        b.push_back(n[15:8]);
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                x = w[i][8*k +: 8];
                b.push_back(x);
                s = s + x;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(s);
`endif
        if (n <= 256) begin
            foreach (w[i]) begin
                exp_addr_q.push_back(i[7:0]);
                exp_data_q.push_back(w[i]);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int k;
        int unsigned g;
        if (gappy) begin
            g = $urandom_range(0, 2);
            repeat (g) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout actual in_ready=0 expected in_ready=1");
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b[$], input bit gappy, input int start_at);
        foreach (b[i]) begin
            if (i == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(b[i], gappy);
        end
    endtask

    task automatic start_load(input bit with_byte, input logic [7:0] b);
        start = 1'b1;
        if (with_byte) begin
            in_valid = 1'b1;
            in_data  = b;
        end
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_err_clr", 32'(error), 32'd0);
    endtask

    task automatic finish_check(input string tag, input int exp_done, input int exp_words,
                                input logic exp_err);
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, 32'(done_seen), 32'(exp_done));
        chk({tag, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        done_seen = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        logic [7:0]  b[$];
        logic [31:0] w[$];

        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Test 1: literal frame and literal expected writes.
        b = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h33, 8'h05, 8'hB5, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(8'h50);
`endif
        exp_addr_q.push_back(8'h00); exp_data_q.push_back(32'h00500013);
        exp_addr_q.push_back(8'h01); exp_data_q.push_back(32'h00B50533);
        start_load(1'b0, 8'h00);
        send_frame(b, 1'b0, -1);
        finish_check("t1", 1, 2, 1'b0);

        // Test 2: empty load; a byte offered alongside start must not be consumed in IDLE.
        w = {};
        build(w, 0, b);
        start_load(1'b1, 8'h00);
        send_frame(b, 1'b0, -1);
        finish_check("t2", 1, 0, 1'b0);

        // Test 3: oversize length, then recovery from ERR.
        b = '{8'h01, 8'h01};
        start_load(1'b0, 8'h00);
        send_frame(b, 1'b0, -1);
        chk("t3_ready", 32'(in_ready), 32'd0);
        finish_check("t3", 0, 0, 1'b1);
        w = {};
        build(w, 0, b);
        start_load(1'b0, 8'h00);
        send_frame(b, 1'b0, -1);
        finish_check("t3rec", 1, 0, 1'b0);

        // Test 4: gappy valid, stray start in the middle of the data.
        chk("t4_ready_idle", 32'(in_ready), 32'd0);
        w = '{32'hDEADBEEF, 32'h01234567, 32'hA5A55A5A};
        build(w, 3, b);
        start_load(1'b0, 8'h00);
        send_frame(b, 1'b1, 7);
        finish_check("t4", 1, 3, 1'b0);

        // Test 5: reset after 5 data bytes; only word 0 is written.
        w = '{32'h11223344, 32'h55667788};
        build(w, 2, b);
        start_load(1'b0, 8'h00);
        for (int i = 0; i < 7; i++) send_byte(b[i], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("t5");
        chk("t5_pending", 32'(exp_addr_q.size()), 32'd1);
        exp_addr_q = {};
        exp_data_q = {};
        done_seen = 0;
        @(negedge clk);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Test 6: corrupted checksum byte.
        w = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h00000001};
        build(w, 3, b);
        b[b.size()-1] = b[b.size()-1] ^ 8'h01;
        start_load(1'b0, 8'h00);
        send_frame(b, 1'b0, -1);
        finish_check("t6", 0, 3, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
